// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/LS/memory bundle for the shared data-memory port arbiter
//
// Purpose: carries every request, grant, response and memory-side signal of
// mem_port_arbiter so the arbiter and its environment connect through one port.
//
// Signals:
//   if_req, if_addr                    instruction-fetch read request
//   if_gnt, if_rvalid, if_rdata        IF grant and read response
//   ls_req, ls_we, ls_addr, ls_wdata,
//   ls_mask, ls_kill                   load/store request
//   ls_gnt, ls_rvalid, ls_rdata        LS grant and read response
//   mem_addr, mem_wdata, mem_mask,
//   mem_read, mem_write                memory issue side
//   mem_rdata                          memory read data
//
// Modports:
//   slave  - the arbiter (consumes requests and mem_rdata)
//   master - the requesters plus memory model (drives requests and mem_rdata)

interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic        ls_kill;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_mask, ls_kill,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_addr, mem_wdata, mem_mask, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_mask, ls_kill,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_addr, mem_wdata, mem_mask, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-memory port between instruction fetch and load/store
//
// Purpose: grants at most one request per cycle (LS priority, with a
// starvation guard that lets IF through after STARVE_LIMIT consecutive
// denied cycles) and steers each read response back to the requester that
// issued it, using a READ_LATENCY-deep {valid, owner} tag pipeline.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset; forces every output to 0
//   bus  - mem_port_arbiter_if.slave: IF/LS requests, grants, responses
//          and the memory issue/return signals
//
// Parameters:
//   READ_LATENCY - cycles from mem_read issue to valid mem_rdata (1..4)
//   STARVE_LIMIT - denied IF cycles before IF wins a contended cycle (1..15)

module mem_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic [3:0]              starve_q, starve_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    // Owner bit per tag stage: 1 = LS, 0 = IF.
    logic [READ_LATENCY-1:0] own_q, own_d;

    logic if_win;
    logic ls_win;
    logic issue_read;
    logic ret_vld;
    logic ret_ls;

    // Arbitration. Requests are ignored while rst is high, which also keeps
    // every combinational output at 0 during reset.
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (!rst) begin
            if (bus.if_req && (!bus.ls_req || (starve_q == STARVE_LIM))) begin
                if_win = 1'b1;
            end else if (bus.ls_req) begin
                ls_win = 1'b1;
            end
        end
    end

    assign issue_read = if_win | (ls_win & ~bus.ls_we);

    assign bus.if_gnt    = if_win;
    assign bus.ls_gnt    = ls_win;
    assign bus.mem_read  = issue_read;
    // A killed store is still granted so the LS unit retires it, but it
    // never reaches memory.
    assign bus.mem_write = ls_win & bus.ls_we & ~bus.ls_kill;
    assign bus.mem_mask  = (ls_win & bus.ls_we) ? bus.ls_mask : 4'b0000;
    assign bus.mem_wdata = ls_win ? bus.ls_wdata : 32'h0000_0000;

    always_comb begin
        bus.mem_addr = 32'h0000_0000;
        if (if_win) begin
            bus.mem_addr = {bus.if_addr[31:2], 2'b00};
        end else if (ls_win) begin
            bus.mem_addr = {bus.ls_addr[31:2], 2'b00};
        end
    end

    // Starvation counter: counts consecutive cycles in which IF asked and
    // lost, saturating at the limit so IF wins the next contended cycle.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || if_win) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Read tag pipeline: stage 0 captures the issue, the last stage lines
    // up with mem_rdata. Stores and idle cycles push an invalid entry.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = issue_read;
        own_d[0] = ls_win;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
            vld_q    <= '0;
            own_q    <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q    <= vld_d;
            own_q    <= own_d;
        end
    end

    // Response steering. Gating with rst keeps rvalid low in the reset
    // cycle itself; the pipeline is cleared at the end of it.
    assign ret_vld = vld_q[READ_LATENCY-1] & ~rst;
    assign ret_ls  = own_q[READ_LATENCY-1];

    assign bus.if_rvalid = ret_vld & ~ret_ls;
    assign bus.ls_rvalid = ret_vld &  ret_ls;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0000_0000;
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : 32'h0000_0000;

    // Byte-offset bits are dropped on purpose: the memory is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mem_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic d1(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [31:0] la, input logic [31:0] wd, input logic [3:0] m,
                      input logic k);
        b1.if_req = ir; b1.if_addr = ia; b1.ls_req = lr; b1.ls_we = lw;
        b1.ls_addr = la; b1.ls_wdata = wd; b1.ls_mask = m; b1.ls_kill = k;
    endtask

    task automatic d3(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [31:0] la, input logic [31:0] wd, input logic [3:0] m,
                      input logic k);
        b3.if_req = ir; b3.if_addr = ia; b3.ls_req = lr; b3.ls_we = lw;
        b3.ls_addr = la; b3.ls_wdata = wd; b3.ls_mask = m; b3.ls_kill = k;
    endtask

    logic        pv, pif, exp_if, exp_iv, exp_lv;
    logic [31:0] rd;

    initial begin
        rst = 1'b1;
        d1(0, 0, 0, 0, 0, 0, 4'h0, 0);
        d3(0, 0, 0, 0, 0, 0, 4'h0, 0);
        b1.mem_rdata = 32'h0;
        b3.mem_rdata = 32'h0;

        // Reset cycle with requests present: everything stays 0.
        tick();
        d1(1, 32'h106, 1, 0, 32'h40, 0, 4'h0, 0);
        #1;
        chk("rst_if_gnt", {31'b0, b1.if_gnt}, 32'd0);
        chk("rst_ls_gnt", {31'b0, b1.ls_gnt}, 32'd0);
        chk("rst_mem_read", {31'b0, b1.mem_read}, 32'd0);
        chk("rst_mem_addr", b1.mem_addr, 32'h0);
        chk("rst_if_rvalid", {31'b0, b1.if_rvalid}, 32'd0);

        // Single IF read, latency 1.
        tick();
        rst = 1'b0;
        d1(1, 32'h0000_0106, 0, 0, 0, 0, 4'h0, 0);
        #1;
        chk("t1_if_gnt", {31'b0, b1.if_gnt}, 32'd1);
        chk("t1_mem_read", {31'b0, b1.mem_read}, 32'd1);
        chk("t1_mem_addr", b1.mem_addr, 32'h104);
        chk("t1_ls_gnt", {31'b0, b1.ls_gnt}, 32'd0);
        tick();
        d1(0, 0, 0, 0, 0, 0, 4'h0, 0);
        b1.mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_if_rvalid", {31'b0, b1.if_rvalid}, 32'd1);
        chk("t1_if_rdata", b1.if_rdata, 32'hDEAD_BEEF);
        chk("t1_ls_rvalid", {31'b0, b1.ls_rvalid}, 32'd0);
        chk("t1_ls_rdata", b1.ls_rdata, 32'h0);

        // Contention: LS,LS,LS,LS,IF repeating; responses follow one cycle later.
        pv = 1'b0;
        pif = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            d1(1, 32'h300, 1, 0, 32'h400, 0, 4'h0, 0);
            rd = 32'hA000_0000 + 32'(i);
            b1.mem_rdata = rd;
            #1;
            exp_if = ((i % 5) == 4);
            chk("st_if_gnt", {31'b0, b1.if_gnt}, {31'b0, exp_if});
            chk("st_ls_gnt", {31'b0, b1.ls_gnt}, {31'b0, ~exp_if});
            chk("st_mem_read", {31'b0, b1.mem_read}, 32'd1);
            chk("st_mem_addr", b1.mem_addr, exp_if ? 32'h300 : 32'h400);
            chk("st_if_rvalid", {31'b0, b1.if_rvalid}, {31'b0, pv & pif});
            chk("st_ls_rvalid", {31'b0, b1.ls_rvalid}, {31'b0, pv & ~pif});
            chk("st_ls_rdata", b1.ls_rdata, (pv & ~pif) ? rd : 32'h0);
            pv = 1'b1;
            pif = exp_if;
        end
        tick();
        d1(0, 0, 0, 0, 0, 0, 4'h0, 0);
        b1.mem_rdata = 32'h5555_AAAA;
        #1;
        chk("st_last_if_rvalid", {31'b0, b1.if_rvalid}, 32'd1);
        chk("st_last_if_rdata", b1.if_rdata, 32'h5555_AAAA);
        chk("st_idle_mem_read", {31'b0, b1.mem_read}, 32'd0);

        // Store, then the same store killed.
        tick();
        d1(0, 0, 1, 1, 32'h20, 32'h1234_0000, 4'b1100, 0);
        #1;
        chk("sw_ls_gnt", {31'b0, b1.ls_gnt}, 32'd1);
        chk("sw_mem_write", {31'b0, b1.mem_write}, 32'd1);
        chk("sw_mem_read", {31'b0, b1.mem_read}, 32'd0);
        chk("sw_mem_mask", {28'b0, b1.mem_mask}, 32'hC);
        chk("sw_mem_wdata", b1.mem_wdata, 32'h1234_0000);
        chk("sw_mem_addr", b1.mem_addr, 32'h20);
        tick();
        d1(0, 0, 1, 1, 32'h20, 32'h1234_0000, 4'b1100, 1);
        #1;
        chk("kill_ls_gnt", {31'b0, b1.ls_gnt}, 32'd1);
        chk("kill_mem_write", {31'b0, b1.mem_write}, 32'd0);
        chk("kill_mem_read", {31'b0, b1.mem_read}, 32'd0);
        chk("sw_no_ls_rvalid", {31'b0, b1.ls_rvalid}, 32'd0);
        chk("sw_no_if_rvalid", {31'b0, b1.if_rvalid}, 32'd0);

        // Misaligned load passes through as a word address.
        tick();
        d1(0, 0, 1, 0, 32'h33, 0, 4'h0, 0);
        #1;
        chk("mis_mem_addr", b1.mem_addr, 32'h30);
        chk("mis_mem_read", {31'b0, b1.mem_read}, 32'd1);
        chk("kill_no_ls_rvalid", {31'b0, b1.ls_rvalid}, 32'd0);
        tick();
        d1(0, 0, 0, 0, 0, 0, 4'h0, 0);
        b1.mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("mis_ls_rvalid", {31'b0, b1.ls_rvalid}, 32'd1);
        chk("mis_ls_rdata", b1.ls_rdata, 32'h0BAD_F00D);

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("idle_gnts", {30'b0, b1.if_gnt, b1.ls_gnt}, 32'd0);
            chk("idle_strobes", {30'b0, b1.mem_read, b1.mem_write}, 32'd0);
            chk("idle_mem_addr", b1.mem_addr, 32'h0);
        end
        tick();
        d1(1, 32'h80, 0, 0, 0, 0, 4'h0, 0);
        #1;
        chk("idle_if_gnt", {31'b0, b1.if_gnt}, 32'd1);
        chk("idle_if_addr", b1.mem_addr, 32'h80);
        tick();
        d1(0, 0, 0, 0, 0, 0, 4'h0, 0);

        // Latency 3: alternating IF/LS reads in cycles 0..3, returns in 3..6.
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c < 4) begin
                if ((c % 2) == 0) d3(1, 32'h100 + 32'(16 * c), 0, 0, 0, 0, 4'h0, 0);
                else              d3(0, 0, 1, 0, 32'h200 + 32'(16 * c), 0, 4'h0, 0);
            end else begin
                d3(0, 0, 0, 0, 0, 0, 4'h0, 0);
            end
            rd = 32'hC0DE_0000 + 32'(c);
            b3.mem_rdata = rd;
            #1;
            if (c < 4) begin
                chk("l3_if_gnt", {31'b0, b3.if_gnt}, {31'b0, ((c % 2) == 0)});
                chk("l3_ls_gnt", {31'b0, b3.ls_gnt}, {31'b0, ((c % 2) == 1)});
            end
            exp_iv = (c >= 3) && (((c - 3) % 2) == 0);
            exp_lv = (c >= 3) && (((c - 3) % 2) == 1);
            chk("l3_if_rvalid", {31'b0, b3.if_rvalid}, {31'b0, exp_iv});
            chk("l3_ls_rvalid", {31'b0, b3.ls_rvalid}, {31'b0, exp_lv});
            chk("l3_if_rdata", b3.if_rdata, exp_iv ? rd : 32'h0);
            chk("l3_ls_rdata", b3.ls_rdata, exp_lv ? rd : 32'h0);
        end

        // Two reads in flight, then a one-cycle reset; counter built up to 2.
        b3.mem_rdata = 32'h7777_7777;
        tick();
        d3(1, 32'h100, 1, 0, 32'h200, 0, 4'h0, 0);
        #1;
        chk("pr_ls_gnt0", {31'b0, b3.ls_gnt}, 32'd1);
        tick();
        #1;
        chk("pr_ls_gnt1", {31'b0, b3.ls_gnt}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("pr_rst_gnts", {30'b0, b3.if_gnt, b3.ls_gnt}, 32'd0);
        chk("pr_rst_rvalid", {30'b0, b3.if_rvalid, b3.ls_rvalid}, 32'd0);
        for (int p = 0; p < 5; p++) begin
            tick();
            rst = 1'b0;
            #1;
            chk("pr_if_gnt", {31'b0, b3.if_gnt}, {31'b0, (p == 4)});
            chk("pr_ls_gnt", {31'b0, b3.ls_gnt}, {31'b0, (p != 4)});
            if (p < 3) begin
                chk("pr_no_rvalid", {30'b0, b3.if_rvalid, b3.ls_rvalid}, 32'd0);
            end
        end
        tick();
        d3(0, 0, 0, 0, 0, 0, 4'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Sits between both requesters and the memory, upstream of the byte-lane controller.
- Grants one request per cycle with LS priority and a starvation guard for IF.
- Tracks in-flight reads so each read response returns to the requester that issued it.

Parameters:
- READ_LATENCY, 1, cycles from the mem_read issue cycle to valid mem_rdata; legal range 1..4.
- STARVE_LIMIT, 4, consecutive denied IF cycles after which IF wins the next contended cycle; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request.
- if_addr  in  32  IF byte address.
- if_gnt  out  1  IF request issued this cycle (combinational).
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  32  read word for IF.
- ls_req  in  1  LS request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  LS byte address.
- ls_wdata  in  32  store data, already lane-aligned.
- ls_mask  in  4  store byte-enable mask.
- ls_kill  in  1  exception in flight; suppresses a store write.
- ls_gnt  out  1  LS request issued this cycle (combinational).
- ls_rvalid  out  1  ls_rdata valid.
- ls_rdata  out  32  read word for LS (raw word; the byte-lane controller does extraction).
- mem_addr  out  32  word address = {winner addr[31:2], 2'b00}.
- mem_wdata  out  32  = ls_wdata when LS wins, else 0.
- mem_mask  out  4  = ls_mask on an LS store, else 0.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset:
  - All outputs 0 while rst = 1.
  - Starvation counter cleared to 0.
  - Read-tag pipeline cleared; reads in flight at reset are dropped and produce no rvalid.
  - Requests are ignored during the rst cycle.
- Arbitration (combinational, same cycle):
  - Only one requester asks: it wins.
  - Both ask: LS wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - Neither asks: no strobe; mem_addr = 0.
  - Exactly one of if_gnt/ls_gnt is 1 whenever any req is 1.
- Issue strobes:
  - IF win: mem_read = 1.
  - LS load win: mem_read = 1.
  - LS store win: mem_write = !ls_kill; ls_gnt = 1 even when killed, so the store is consumed and dropped.
  - mem_read and mem_write are never both 1.
- Starvation counter (4 bit):
  - Increments when if_req & !if_gnt.
  - Clears to 0 on if_gnt or when !if_req.
  - Saturates at STARVE_LIMIT.
- Read return:
  - Shift register of READ_LATENCY entries, each {valid, owner}, shifts every cycle.
  - Entry 0 loads {mem_read, owner = IF/LS} at issue.
  - When the last stage is valid:
    - owner = IF: if_rvalid = 1, if_rdata = mem_rdata.
    - owner = LS: ls_rvalid = 1, ls_rdata = mem_rdata.
  - rdata outputs are 0 when the matching rvalid is 0.
  - Rvalids are registered-path outputs; a read issued in cycle N returns in cycle N+READ_LATENCY.
  - Back-to-back reads are fully pipelined; responses keep issue order.
  - Stores allocate an invalid entry.
- Requesters hold req/addr/data stable until their gnt is seen; there is no back-pressure on the response path.
- Misaligned LS addresses pass through as a word address; alignment checking belongs upstream.

Test Plan:
- Reset, then if_req = 1, if_addr = 0x0000_0106, READ_LATENCY = 1:
  - Cycle 0: if_gnt = 1, mem_read = 1, mem_addr = 0x104.
  - Cycle 1: drive mem_rdata = 0xDEADBEEF → if_rvalid = 1, if_rdata = 0xDEADBEEF, ls_rvalid = 0.
- Both request continuously, STARVE_LIMIT = 4, LS load stream:
  - Grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF…; starve_cnt = 0 after each IF grant.
- LS store ls_addr = 0x20, ls_mask = 4'b1100, ls_wdata = 0x12340000:
  - mem_write = 1, mem_mask = 4'b1100, mem_wdata = 0x12340000, no rvalid.
  - Same store with ls_kill = 1: ls_gnt = 1, mem_write = 0.
- READ_LATENCY = 3, alternating IF/LS reads issued in cycles 0..3:
  - Rvalids appear in cycles 3..6 as IF,LS,IF,LS with the matching mem_rdata values.
- Assert rst for one cycle with two reads in flight (READ_LATENCY = 3):
  - No if_rvalid/ls_rvalid in the following 3 cycles.
  - Counter is 0 after reset.
- Idle (no reqs) for 10 cycles:
  - All strobes and gnts stay 0, mem_addr = 0.
  - A pending if_req held through 10 LS-only-free cycles is granted immediately.
